// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: one op at a time over a req/gnt/rvalid data port.
// Loads are lane-extracted and extended; stores are lane-replicated with byte enables.
module lsu_mem_ctrl #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [3:0]        req_lsuop,
  input  logic [4:0]        req_rd,
  input  logic              req_rf_en,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_rf_en,
  output logic              rsp_fault,
  output logic [1:0]        rsp_cause,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [1:0]        dbg_state
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = (XLEN == 64) ? 3 : 2;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] op_addr;
  logic [XLEN-1:0]   op_wdata;
  logic              op_store, op_unsigned, op_rf_en;
  logic [1:0]        op_size;
  logic [4:0]        op_rd;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [OFF_W-1:0]  req_off, size_mask, op_off;
  logic              req_bad, accept, tmo_hit, done_ok, done_tmo;
  logic [7:0]        lane_mask;
  logic [BE_W-1:0]   st_be;
  logic [XLEN-1:0]   st_wdata, ld_shift, ld_keep, ld_data;
  logic              ld_msb;

  // Handshake: an op transfers on a cycle with req_valid && req_ready; req_ready is high only in IDLE.
  assign accept    = req_valid && (state == S_IDLE);
  assign op_off    = op_addr[OFF_W-1:0];
  assign tmo_hit   = (tmo_cnt == TMO_LIMIT);
  assign done_ok   = (state == S_WAIT) && dmem_rvalid;
  assign done_tmo  = tmo_hit && (((state == S_REQ) && !dmem_gnt) ||
                                 ((state == S_WAIT) && !dmem_rvalid));
  assign dbg_state = state;

  always_comb begin
    req_off   = req_addr[OFF_W-1:0];
    size_mask = OFF_W'((4'd1 << req_lsuop[1:0]) - 4'd1);
    req_bad   = ((req_off & size_mask) != '0) || ((XLEN == 32) && (req_lsuop[1:0] == 2'd3));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = req_bad ? S_RESP : S_REQ;
      S_REQ: begin
        if (dmem_gnt) state_nxt = S_WAIT;
        else if (tmo_hit) state_nxt = S_RESP;
      end
      S_WAIT: if (dmem_rvalid || tmo_hit) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Store lanes: low bytes of the data replicated, enables shifted to the byte offset.
  always_comb begin
    case (op_size)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
    st_be = BE_W'(lane_mask) << op_off;
    case (op_size)
      2'd0:    st_wdata = {BE_W{op_wdata[7:0]}};
      2'd1:    st_wdata = {(XLEN/16){op_wdata[15:0]}};
      2'd2:    st_wdata = {(XLEN/32){op_wdata[31:0]}};
      default: st_wdata = op_wdata;
    endcase
  end

  always_comb begin
    ld_shift = dmem_rdata >> {op_off, 3'b000};
    case (op_size)
      2'd0: begin ld_keep = XLEN'(8'hFF);        ld_msb = ld_shift[7];  end
      2'd1: begin ld_keep = XLEN'(16'hFFFF);     ld_msb = ld_shift[15]; end
      2'd2: begin ld_keep = XLEN'(32'hFFFF_FFFF); ld_msb = ld_shift[31]; end
      default: begin ld_keep = '1;               ld_msb = 1'b0;         end
    endcase
    ld_data = (ld_shift & ld_keep) | ((ld_msb && !op_unsigned) ? ~ld_keep : '0);
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    stall      = (state != S_IDLE);
    rsp_valid  = (state == S_RESP);
    dmem_req   = (state == S_REQ);
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    if (state == S_REQ) begin
      dmem_we    = op_store;
      dmem_addr  = {op_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      dmem_be    = op_store ? st_be : '1;
      dmem_wdata = op_store ? st_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_addr     <= '0;
      op_wdata    <= '0;
      op_store    <= 1'b0;
      op_unsigned <= 1'b0;
      op_size     <= 2'd0;
      op_rd       <= 5'd0;
      op_rf_en    <= 1'b0;
      tmo_cnt     <= '0;
      rsp_rdata   <= '0;
      rsp_rd      <= 5'd0;
      rsp_rf_en   <= 1'b0;
      rsp_fault   <= 1'b0;
      rsp_cause   <= 2'd0;
    end else begin
      if ((state == S_REQ) || (state == S_WAIT)) tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (accept) begin
        op_addr     <= req_addr;
        op_wdata    <= req_wdata;
        op_store    <= req_lsuop[3];
        op_unsigned <= req_lsuop[2];
        op_size     <= req_lsuop[1:0];
        op_rd       <= req_rd;
        op_rf_en    <= req_rf_en;
        tmo_cnt     <= '0;
        if (req_bad) begin
          rsp_rdata <= '0;
          rsp_rd    <= req_rd;
          rsp_rf_en <= 1'b0;
          rsp_fault <= 1'b1;
          rsp_cause <= req_lsuop[3] ? 2'd2 : 2'd1;
        end
      end
      if (done_ok) begin
        rsp_rdata <= op_store ? '0 : ld_data;
        rsp_rd    <= op_rd;
        rsp_rf_en <= op_rf_en;
        rsp_fault <= 1'b0;
        rsp_cause <= 2'd0;
      end else if (done_tmo) begin
        rsp_rdata <= '0;
        rsp_rd    <= op_rd;
        rsp_rf_en <= 1'b0;
        rsp_fault <= 1'b1;
        rsp_cause <= 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a 32-bit instance (short timeout) and a 64-bit instance
// share stimulus; the c_* view selects which instance the current test observes.
module tb_lsu_mem_ctrl;
  logic clk;
  logic rst, req_valid, req_rf_en, dmem_gnt, dmem_rvalid, sel64;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, dmem_rdata;
  logic [3:0]  req_lsuop;
  logic [4:0]  req_rd;

  logic        a_req_ready, a_rsp_valid, a_rsp_rf_en, a_rsp_fault, a_stall, a_dmem_req, a_dmem_we;
  logic [31:0] a_rsp_rdata, a_dmem_addr, a_dmem_wdata;
  logic [4:0]  a_rsp_rd;
  logic [1:0]  a_rsp_cause, a_dbg_state;
  logic [3:0]  a_dmem_be;
  logic        b_req_ready, b_rsp_valid, b_rsp_rf_en, b_rsp_fault, b_stall, b_dmem_req, b_dmem_we;
  logic [63:0] b_rsp_rdata, b_dmem_wdata;
  logic [31:0] b_dmem_addr;
  logic [4:0]  b_rsp_rd;
  logic [1:0]  b_rsp_cause, b_dbg_state;
  logic [7:0]  b_dmem_be;

  logic        c_ready, c_rsp_valid, c_rf_en, c_fault, c_stall, c_dmem_req, c_we;
  logic [63:0] c_rdata, c_wdata;
  logic [31:0] c_addr;
  logic [4:0]  c_rd;
  logic [1:0]  c_cause;
  logic [7:0]  c_be;

  int checks, failures;
  int obs_lat;
  logic obs_ready, obs_req_seen, obs_we;
  logic [7:0]  obs_be;
  logic [63:0] obs_wdata;
  logic [31:0] obs_addr;

  lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .req_lsuop(req_lsuop), .req_rd(req_rd), .req_rf_en(req_rf_en),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_rd(a_rsp_rd), .rsp_rf_en(a_rsp_rf_en),
    .rsp_fault(a_rsp_fault), .rsp_cause(a_rsp_cause), .stall(a_stall), .dmem_req(a_dmem_req),
    .dmem_we(a_dmem_we), .dmem_addr(a_dmem_addr), .dmem_be(a_dmem_be), .dmem_wdata(a_dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata[31:0]),
    .dbg_state(a_dbg_state));

  lsu_mem_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(255)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_lsuop(req_lsuop), .req_rd(req_rd), .req_rf_en(req_rf_en),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_rd(b_rsp_rd), .rsp_rf_en(b_rsp_rf_en),
    .rsp_fault(b_rsp_fault), .rsp_cause(b_rsp_cause), .stall(b_stall), .dmem_req(b_dmem_req),
    .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_be(b_dmem_be), .dmem_wdata(b_dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dbg_state(b_dbg_state));

  always_comb begin
    if (sel64) begin
      c_ready = b_req_ready; c_rsp_valid = b_rsp_valid; c_rf_en = b_rsp_rf_en; c_fault = b_rsp_fault;
      c_stall = b_stall; c_dmem_req = b_dmem_req; c_we = b_dmem_we; c_rdata = b_rsp_rdata;
      c_wdata = b_dmem_wdata; c_addr = b_dmem_addr; c_rd = b_rsp_rd; c_cause = b_rsp_cause; c_be = b_dmem_be;
    end else begin
      c_ready = a_req_ready; c_rsp_valid = a_rsp_valid; c_rf_en = a_rsp_rf_en; c_fault = a_rsp_fault;
      c_stall = a_stall; c_dmem_req = a_dmem_req; c_we = a_dmem_we; c_rdata = {32'h0, a_rsp_rdata};
      c_wdata = {32'h0, a_dmem_wdata}; c_addr = a_dmem_addr; c_rd = a_rsp_rd; c_cause = a_rsp_cause;
      c_be = {4'h0, a_dmem_be};
    end
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Drives one op at cycle 0, grants on the first dmem_req, answers rvalid one cycle later
  // (unless give_rvalid is 0) and returns at the negedge where rsp_valid is seen (obs_lat = 0 if never).
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic [4:0] rd, input bit give_rvalid);
    bit granted;
    granted = 1'b0;
    obs_lat = 0; obs_req_seen = 1'b0; obs_be = '0; obs_wdata = '0; obs_addr = '0; obs_we = 1'b0;
    @(negedge clk);
    obs_ready = c_ready;
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_lsuop = op; req_rd = rd; req_rf_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 20 && obs_lat == 0; c++) begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (c_rsp_valid) obs_lat = c;
      else begin
        if (c_dmem_req && !granted) begin
          obs_req_seen = 1'b1; obs_be = c_be; obs_wdata = c_wdata; obs_addr = c_addr; obs_we = c_we;
          dmem_gnt = 1'b1; granted = 1'b1;
        end else if (granted && give_rvalid) begin
          dmem_rvalid = 1'b1; dmem_rdata = rdata;
        end
        @(negedge clk);
      end
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_lsuop = '0; req_rd = '0;
    req_rf_en = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; sel64 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (c_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", c_ready); end
    checks++; if (c_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", c_rsp_valid); end
    checks++; if (c_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", c_stall); end
    checks++; if (c_dmem_req !== 1'b0 || c_be !== 8'h0) begin failures++; $display("FAIL reset_dmem got req=%b be=%h exp 0/0", c_dmem_req, c_be); end
    checks++; if (c_rdata !== 64'h0 || c_fault !== 1'b0) begin failures++; $display("FAIL reset_rsp got rdata=%h fault=%b exp 0/0", c_rdata, c_fault); end
    checks++; if (a_dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", a_dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_op(4'b0010, 32'h1000, 64'h0, 64'hDEADBEEF, 5'd5, 1'b1);
    checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", obs_ready); end
    checks++; if (obs_lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", obs_lat); end
    checks++; if (obs_addr !== 32'h1000 || obs_be !== 8'h0F || obs_we !== 1'b0) begin failures++; $display("FAIL lw_dmem got addr=%h be=%h we=%b exp 1000/0f/0", obs_addr, obs_be, obs_we); end
    checks++; if (c_rdata !== 64'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", c_rdata); end
    checks++; if (c_rd !== 5'd5 || c_rf_en !== 1'b1 || c_fault !== 1'b0 || c_cause !== 2'd0) begin failures++; $display("FAIL lw_rsp got rd=%0d rf_en=%b fault=%b cause=%0d exp 5/1/0/0", c_rd, c_rf_en, c_fault, c_cause); end
    checks++; if (c_ready !== 1'b0) begin failures++; $display("FAIL lw_ready_in_resp got=%b exp=0", c_ready); end
    @(negedge clk);
    checks++; if (c_rsp_valid !== 1'b0 || c_rdata !== 64'hDEADBEEF || c_ready !== 1'b1) begin failures++; $display("FAIL lw_hold got valid=%b rdata=%h ready=%b exp 0/deadbeef/1", c_rsp_valid, c_rdata, c_ready); end
  endtask

  task automatic test_load_ext();
    logic [3:0]  ops  [4] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101};
    logic [31:0] adr  [4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000};
    logic [63:0] expv [4] = '{64'hFFFFFF80, 64'h00000080, 64'hFFFF8011, 64'h00002233};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], adr[i], 64'h0, 64'h80112233, 5'd9, 1'b1);
      checks++; if (obs_lat !== 3 || c_rdata !== expv[i]) begin failures++; $display("FAIL load_ext[%0d] got lat=%0d rdata=%h exp 3/%h", i, obs_lat, c_rdata, expv[i]); end
    end
  endtask

  task automatic test_store();
    logic [3:0]  ops  [3] = '{4'b1001, 4'b1100, 4'b1010};
    logic [31:0] adr  [3] = '{32'h2002, 32'h2001, 32'h2004};
    logic [63:0] wd   [3] = '{64'h0000ABCD, 64'h123456EF, 64'h11223344};
    logic [7:0]  ebe  [3] = '{8'h0C, 8'h02, 8'h0F};
    logic [63:0] ewd  [3] = '{64'hABCDABCD, 64'hEFEFEFEF, 64'h11223344};
    logic [31:0] eadr [3] = '{32'h2000, 32'h2000, 32'h2004};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], adr[i], wd[i], 64'h12345678, 5'd0, 1'b1);
      checks++; if (obs_be !== ebe[i] || obs_wdata !== ewd[i] || obs_addr !== eadr[i] || obs_we !== 1'b1) begin failures++; $display("FAIL store[%0d] got be=%h wdata=%h addr=%h we=%b exp %h/%h/%h/1", i, obs_be, obs_wdata, obs_addr, obs_we, ebe[i], ewd[i], eadr[i]); end
      checks++; if (obs_lat !== 3 || c_rdata !== 64'h0 || c_fault !== 1'b0) begin failures++; $display("FAIL store_rsp[%0d] got lat=%0d rdata=%h fault=%b exp 3/0/0", i, obs_lat, c_rdata, c_fault); end
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]  ops [4] = '{4'b0010, 4'b1001, 4'b1010, 4'b0011};
    logic [31:0] adr [4] = '{32'h1001, 32'h2001, 32'h2002, 32'h0000};
    logic [1:0]  ec  [4] = '{2'd1, 2'd2, 2'd2, 2'd1};
    run_op(4'b0010, 32'h1000, 64'h0, 64'hCAFEF00D, 5'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], adr[i], 64'hFFFF, 64'h0, 5'(i + 10), 1'b1);
      checks++; if (obs_req_seen !== 1'b0 || obs_lat < 1 || obs_lat > 2) begin failures++; $display("FAIL misalign_timing[%0d] got req_seen=%b lat=%0d exp 0 and lat 1..2", i, obs_req_seen, obs_lat); end
      checks++; if (c_fault !== 1'b1 || c_cause !== ec[i] || c_rf_en !== 1'b0 || c_rdata !== 64'h0 || c_rd !== 5'(i + 10)) begin failures++; $display("FAIL misalign_rsp[%0d] got fault=%b cause=%0d rf_en=%b rdata=%h rd=%0d exp 1/%0d/0/0/%0d", i, c_fault, c_cause, c_rf_en, c_rdata, c_rd, ec[i], i + 10); end
    end
  endtask

  task automatic test_timeout();
    int n_req, lat;
    n_req = 0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h3000; req_lsuop = 4'b0010; req_rd = 5'd4; req_rf_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c_rsp_valid) lat = c;
      else begin
        if (c_dmem_req) n_req++;
        @(negedge clk);
      end
    end
    checks++; if (n_req !== 5 || lat !== 6) begin failures++; $display("FAIL timeout_req got req_cycles=%0d lat=%0d exp 5/6", n_req, lat); end
    checks++; if (c_fault !== 1'b1 || c_cause !== 2'd3 || c_rf_en !== 1'b0) begin failures++; $display("FAIL timeout_rsp got fault=%b cause=%0d rf_en=%b exp 1/3/0", c_fault, c_cause, c_rf_en); end
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 64'h5555AAAA;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checks++; if (c_rsp_valid !== 1'b0 || c_ready !== 1'b1 || c_cause !== 2'd3) begin failures++; $display("FAIL timeout_late_rvalid got valid=%b ready=%b cause=%0d exp 0/1/3", c_rsp_valid, c_ready, c_cause); end
    run_op(4'b0010, 32'h3004, 64'h0, 64'h0, 5'd6, 1'b0);
    checks++; if (obs_req_seen !== 1'b1 || obs_lat !== 6 || c_cause !== 2'd3 || c_fault !== 1'b1) begin failures++; $display("FAIL timeout_wait got req_seen=%b lat=%0d cause=%0d fault=%b exp 1/6/3/1", obs_req_seen, obs_lat, c_cause, c_fault); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1000; req_lsuop = 4'b0010; req_rd = 5'd2; req_rf_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (c_dmem_req !== 1'b1) begin failures++; $display("FAIL rstmid_req_before got=%b exp=1", c_dmem_req); end
    rst = 1'b1;
    #1;
    checks++; if (c_dmem_req !== 1'b0 || c_ready !== 1'b1) begin failures++; $display("FAIL rstmid_req_drop got req=%b ready=%b exp 0/1", c_dmem_req, c_ready); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (c_ready !== 1'b1 || c_stall !== 1'b0) begin failures++; $display("FAIL rstmid_wait got ready=%b stall=%b exp 1/0", c_ready, c_stall); end
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h77777777;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dmem_rvalid = 1'b0;
      if (c_rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || c_ready !== 1'b1) begin failures++; $display("FAIL rstmid_no_rsp got rsp_seen=%b ready=%b exp 0/1", seen, c_ready); end
    run_op(4'b0010, 32'h1000, 64'h0, 64'h0BADCAFE, 5'd8, 1'b1);
    checks++; if (obs_lat !== 3 || c_rdata !== 64'h0BADCAFE || c_rd !== 5'd8) begin failures++; $display("FAIL rstmid_recover got lat=%0d rdata=%h rd=%0d exp 3/0badcafe/8", obs_lat, c_rdata, c_rd); end
  endtask

  task automatic test_back_to_back();
    int pulses, first, last;
    pulses = 0; first = 0; last = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1004; req_lsuop = 4'b0010; req_rd = 5'd1; req_rf_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (c_rsp_valid) begin pulses++; last = c; if (first == 0) first = c; end
      if (c_dmem_req) dmem_gnt = 1'b1;
      else if (c_stall && !c_rsp_valid) begin dmem_rvalid = 1'b1; dmem_rdata = 64'h1; end
      if (c == 5) req_valid = 1'b0;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    checks++; if (pulses !== 2 || first !== 3 || last !== 7) begin failures++; $display("FAIL back_to_back got pulses=%0d first=%0d last=%0d exp 2/3/7", pulses, first, last); end
  endtask

  task automatic test_xlen64();
    sel64 = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_op(4'b0011, 32'h8, 64'h0, 64'h0123456789ABCDEF, 5'd11, 1'b1);
    checks++; if (obs_lat !== 3 || c_rdata !== 64'h0123456789ABCDEF || obs_be !== 8'hFF || obs_addr !== 32'h8) begin failures++; $display("FAIL x64_ld got lat=%0d rdata=%h be=%h addr=%h exp 3/0123456789abcdef/ff/8", obs_lat, c_rdata, obs_be, obs_addr); end
    run_op(4'b0011, 32'hC, 64'h0, 64'h0, 5'd12, 1'b1);
    checks++; if (obs_req_seen !== 1'b0 || c_fault !== 1'b1 || c_cause !== 2'd1) begin failures++; $display("FAIL x64_ld_misalign got req_seen=%b fault=%b cause=%0d exp 0/1/1", obs_req_seen, c_fault, c_cause); end
    run_op(4'b0010, 32'hC, 64'h0, 64'h8765432100000000, 5'd13, 1'b1);
    checks++; if (c_rdata !== 64'hFFFFFFFF87654321 || obs_addr !== 32'h8) begin failures++; $display("FAIL x64_lw got rdata=%h addr=%h exp ffffffff87654321/8", c_rdata, obs_addr); end
    run_op(4'b1010, 32'hC, 64'hAABBCCDD, 64'h0, 5'd0, 1'b1);
    checks++; if (obs_be !== 8'hF0 || obs_wdata !== 64'hAABBCCDDAABBCCDD) begin failures++; $display("FAIL x64_sw got be=%h wdata=%h exp f0/aabbccddaabbccdd", obs_be, obs_wdata); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_xlen64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
